// File: rtl/ahb_lite_master_arb.sv
// AHB3-Lite single-slave master shared by two requesters under round-robin arbitration.
// One transfer in flight at a time; malformed requests are answered locally with an error.
module ahb_lite_master_arb #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [1:0]            req_i,
  input  logic [HADDR_SIZE-1:0] addr0_i,
  input  logic [HADDR_SIZE-1:0] addr1_i,
  input  logic                  write0_i,
  input  logic                  write1_i,
  input  logic [2:0]            size0_i,
  input  logic [2:0]            size1_i,
  input  logic [HDATA_SIZE-1:0] wdata0_i,
  input  logic [HDATA_SIZE-1:0] wdata1_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            ack_o,
  output logic                  err_o,
  output logic [HDATA_SIZE-1:0] rdata_o,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HREADY,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADYOUT,
  input  logic                  HRESP
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    REJ  = 2'b11
  } state_t;

  state_t                  state_r;
  logic                    last_r;
  logic [HDATA_SIZE-1:0]   wdata_r;

  logic [1:0]              elig_s;
  logic                    pick_s;
  logic [HADDR_SIZE-1:0]   addr_s;
  logic                    write_s;
  logic [2:0]              size_s;
  logic [HDATA_SIZE-1:0]   wdata_s;
  logic                    bad_s;

  // Sizes above a word, or addresses not aligned to the size, cannot be issued on the bus.
  function automatic logic bad_request(input logic [2:0] size, input logic [1:0] addr_lsb);
    logic bad;
    case (size)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr_lsb[0];
      3'b010:  bad = |addr_lsb;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Arbitration: a requester being acked this cycle sits out; ties go to the one not served last.
  always_comb begin
    elig_s = req_i & ~ack_o;
    if (elig_s == 2'b11) begin
      pick_s = ~last_r;
    end else if (elig_s[1]) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (pick_s) begin
      addr_s  = addr1_i;
      write_s = write1_i;
      size_s  = size1_i;
      wdata_s = wdata1_i;
    end else begin
      addr_s  = addr0_i;
      write_s = write0_i;
      size_s  = size0_i;
      wdata_s = wdata0_i;
    end
    bad_s = bad_request(size_s, addr_s[1:0]);
  end

  assign HREADY = HREADYOUT;

  // Transfer sequencer with registered requester-side and AHB-side outputs.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      wdata_r <= {HDATA_SIZE{1'b0}};
      gnt_o   <= 2'b00;
      ack_o   <= 2'b00;
      err_o   <= 1'b0;
      rdata_o <= {HDATA_SIZE{1'b0}};
      HSEL    <= 1'b0;
      HADDR   <= {HADDR_SIZE{1'b0}};
      HWDATA  <= {HDATA_SIZE{1'b0}};
      HWRITE  <= 1'b0;
      HSIZE   <= 3'b000;
      HBURST  <= 3'b000;
      HPROT   <= 4'b0011;
      HTRANS  <= 2'b00;
    end else begin
      ack_o <= 2'b00;
      err_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|elig_s) begin
            last_r <= pick_s;
            gnt_o  <= pick_s ? 2'b10 : 2'b01;
            if (bad_s) begin
              state_r <= REJ;
            end else begin
              state_r <= ADDR;
              HSEL    <= 1'b1;
              HTRANS  <= 2'b10;
              HADDR   <= addr_s;
              HWRITE  <= write_s;
              HSIZE   <= size_s;
              wdata_r <= wdata_s;
            end
          end
        end
        ADDR: begin
          if (HREADYOUT) begin
            state_r <= DATA;
            HSEL    <= 1'b0;
            HTRANS  <= 2'b00;
            HWDATA  <= wdata_r;
          end
        end
        DATA: begin
          // A first error cycle arrives with HREADYOUT low, so completion waits for the second.
          if (HREADYOUT) begin
            state_r <= IDLE;
            ack_o   <= gnt_o;
            err_o   <= HRESP;
            gnt_o   <= 2'b00;
            if (!HWRITE) begin
              rdata_o <= HRDATA;
            end
          end
        end
        REJ: begin
          state_r <= IDLE;
          ack_o   <= gnt_o;
          err_o   <= 1'b1;
          gnt_o   <= 2'b00;
        end
        default: begin
          state_r <= IDLE;
          gnt_o   <= 2'b00;
          HSEL    <= 1'b0;
          HTRANS  <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_arb.sv
// Bench for ahb_lite_master_arb: directed and random two-requester traffic, a wait-state/error
// slave, and a transaction-level model feeding scoreboard queues drained by a bus monitor.
module tb_ahb_lite_master_arb;

  logic        HCLK;
  logic        HRESETn;
  logic [1:0]  req_i;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic        write0_i, write1_i;
  logic [2:0]  size0_i, size1_i;
  logic [1:0]  gnt_o, ack_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP;

  ahb_lite_master_arb #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .write0_i(write0_i), .write1_i(write1_i),
    .size0_i(size0_i), .size1_i(size1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct { logic [31:0] addr; logic wr; logic [2:0] size; logic [31:0] wdata; } req_t;
  typedef struct { logic [1:0] who; logic err; logic rd; logic [31:0] rdata; } ack_t;
  typedef struct { logic [1:0] who; logic [31:0] addr; logic wr; logic [2:0] size; logic [31:0] wdata; } xfer_t;

  req_t  q0[$];
  req_t  q1[$];
  ack_t  exp_q[$];
  xfer_t xfer_q[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          rr_last = 1'b1;
  logic [31:0] last_rd = 32'h0;
  int          fixed_wait = -1;
  int          max_wait = 3;
  int          req_cyc = 0, addr_cyc = 0, ack_cyc = 0;
  logic        cur_wr = 1'b0;
  logic [31:0] cur_wdata = 32'h0;
  int          slv_left = 0;
  bit          slv_first = 1'b0, slv_err = 1'b0;
  logic [31:0] slv_addr = 32'h0;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'h1234_5638;
  endfunction

  function automatic bit err_fn(input logic [31:0] a);
    return a[11:8] == 4'hE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_o), 32'h0);
    chk({tag, "_ack"}, 32'(ack_o), 32'h0);
    chk({tag, "_err"}, 32'(err_o), 32'h0);
    chk({tag, "_rdata"}, rdata_o, 32'h0);
    chk({tag, "_hsel"}, 32'(HSEL), 32'h0);
    chk({tag, "_htrans"}, 32'(HTRANS), 32'h0);
    chk({tag, "_haddr"}, HADDR, 32'h0);
    chk({tag, "_hwdata"}, HWDATA, 32'h0);
    chk({tag, "_hwrite"}, 32'(HWRITE), 32'h0);
    chk({tag, "_hsize"}, 32'(HSIZE), 32'h0);
    chk({tag, "_hburst"}, 32'(HBURST), 32'h0);
    chk({tag, "_hprot"}, 32'(HPROT), 32'h3);
  endtask

  // Reference model: service order from the round-robin rule, outcome from size/alignment and slave map.
  task automatic predict();
    int    i0 = 0;
    int    i1 = 0;
    bit    who;
    bit    bad;
    req_t  r;
    ack_t  a;
    xfer_t x;
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) who = !rr_last;
      else who = (i0 < q0.size()) ? 1'b0 : 1'b1;
      rr_last = who;
      if (who) begin r = q1[i1]; i1++; end
      else begin r = q0[i0]; i0++; end
      bad = (r.size > 3'd2) || ((int'(r.addr[1:0]) % (1 << int'(r.size))) != 0);
      a.who   = who ? 2'b10 : 2'b01;
      a.err   = bad ? 1'b1 : err_fn(r.addr);
      a.rd    = !bad && !r.wr;
      a.rdata = rd_fn(r.addr);
      exp_q.push_back(a);
      if (!bad) begin
        x.who = a.who; x.addr = r.addr; x.wr = r.wr; x.size = r.size; x.wdata = r.wdata;
        xfer_q.push_back(x);
      end
    end
  endtask

  task automatic add_req(input int who, input logic [31:0] addr, input logic wr,
                         input logic [2:0] size, input logic [31:0] wdata);
    req_t r;
    r.addr = addr; r.wr = wr; r.size = size; r.wdata = wdata;
    if (who == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic add_rand(input int who);
    req_t r;
    r.size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    r.addr = $urandom & 32'h0000_0FFF;
    if ($urandom_range(0, 4) != 0 && r.size <= 3'd2)
      r.addr = r.addr & ~((32'd1 << r.size) - 32'd1);
    r.wr    = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    if (who == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic apply(input int i0, input int i1);
    req_i[0] = (i0 < q0.size());
    req_i[1] = (i1 < q1.size());
    if (i0 < q0.size()) begin
      addr0_i = q0[i0].addr; write0_i = q0[i0].wr; size0_i = q0[i0].size; wdata0_i = q0[i0].wdata;
    end
    if (i1 < q1.size()) begin
      addr1_i = q1[i1].addr; write1_i = q1[i1].wr; size1_i = q1[i1].size; wdata1_i = q1[i1].wdata;
    end
  endtask

  // Each requester holds its current request until acked, then presents its next one at once.
  task automatic run_episode();
    int i0 = 0;
    int i1 = 0;
    int budget = 0;
    predict();
    @(negedge HCLK);
    req_cyc = cyc;
    apply(i0, i1);
    while ((i0 < q0.size() || i1 < q1.size()) && budget < 400) begin
      @(negedge HCLK);
      budget++;
      if (ack_o[0] && i0 < q0.size()) i0++;
      if (ack_o[1] && i1 < q1.size()) i1++;
      apply(i0, i1);
    end
    if (budget >= 400) chk("episode_timeout", 32'd1, 32'd0);
    req_i = 2'b00;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge HCLK);
  endtask

  // Slave: random or fixed wait states, two-cycle error for the error region, read data from address.
  initial begin
    forever begin
      @(negedge HCLK);
      if (slv_left > 0) begin
        if (slv_first) begin
          if (cur_wr) chk("hwdata", HWDATA, cur_wdata);
          slv_first = 1'b0;
        end
        slv_left--;
        if (slv_left == 0) begin
          HREADYOUT = 1'b1; HRESP = slv_err; HRDATA = rd_fn(slv_addr);
        end else if (slv_err && slv_left == 1) begin
          HREADYOUT = 1'b0; HRESP = 1'b1; HRDATA = $urandom;
        end else begin
          HREADYOUT = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
        end
      end else begin
        HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        if (HRESETn === 1'b1 && HTRANS == 2'b10) begin
          slv_addr  = HADDR;
          slv_err   = err_fn(HADDR);
          slv_left  = ((fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait)))
                      + 1 + (slv_err ? 1 : 0);
          slv_first = 1'b1;
        end
      end
      #1 chk("hready", 32'(HREADY), 32'(HREADYOUT));
    end
  end

  // Monitor: pops expected completions on ack and expected bus transfers on address phases.
  initial begin
    ack_t  e;
    xfer_t x;
    forever begin
      @(negedge HCLK);
      if (HRESETn === 1'b1) begin
        if (ack_o != 2'b00) begin
          ack_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("ack_unexpected", 32'(ack_o), 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("ack_who", 32'(ack_o), 32'(e.who));
            chk("ack_err", 32'(err_o), 32'(e.err));
            chk("ack_rdata", rdata_o, e.rd ? e.rdata : last_rd);
            chk("ack_gnt_idle", 32'(gnt_o), 32'h0);
            if (e.rd) last_rd = e.rdata;
          end
        end else begin
          chk("err_without_ack", 32'(err_o), 32'h0);
        end
        if (HTRANS == 2'b10) begin
          addr_cyc = cyc;
          chk("addr_hsel", 32'(HSEL), 32'h1);
          chk("addr_hburst", 32'(HBURST), 32'h0);
          chk("addr_hprot", 32'(HPROT), 32'h3);
          if (xfer_q.size() == 0) begin
            chk("xfer_unexpected", 32'(HTRANS), 32'h0);
          end else begin
            x = xfer_q.pop_front();
            chk("addr_gnt", 32'(gnt_o), 32'(x.who));
            chk("addr_haddr", HADDR, x.addr);
            chk("addr_hwrite", 32'(HWRITE), 32'(x.wr));
            chk("addr_hsize", 32'(HSIZE), 32'(x.size));
            cur_wr = x.wr;
            cur_wdata = x.wdata;
          end
        end else begin
          chk("idle_htrans", 32'(HTRANS), 32'h0);
          chk("idle_hsel", 32'(HSEL), 32'h0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETn = 1'b0; req_i = 2'b00;
    addr0_i = 32'h0; addr1_i = 32'h0; wdata0_i = 32'h0; wdata1_i = 32'h0;
    write0_i = 1'b0; write1_i = 1'b0; size0_i = 3'b000; size1_i = 3'b000;
    HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1 check_reset_values("rst");
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Zero-wait word write: address phase, data phase and ack one cycle apart.
    fixed_wait = 0;
    add_req(0, 32'h100, 1'b1, 3'b010, 32'hDEADBEEF);
    run_episode();
    chk("wr_addr_latency", 32'(addr_cyc - req_cyc), 32'd1);
    chk("wr_ack_latency", 32'(ack_cyc - req_cyc), 32'd3);

    // Misaligned word: answered locally, two cycles after the request.
    add_req(0, 32'h102, 1'b0, 3'b010, 32'h0);
    run_episode();
    chk("rej_ack_latency", 32'(ack_cyc - req_cyc), 32'd2);

    // Read with three wait states.
    fixed_wait = 3;
    add_req(0, 32'h40, 1'b0, 3'b010, 32'h0);
    run_episode();
    chk("wait_ack_latency", 32'(ack_cyc - addr_cyc), 32'd5);
    chk("wait_rdata_hold", rdata_o, 32'h12345678);

    // Two-cycle error on a write, then a normal transfer.
    fixed_wait = 0;
    add_req(1, 32'hE00, 1'b1, 3'b010, 32'hCAFEF00D);
    run_episode();
    chk("err_ack_latency", 32'(ack_cyc - addr_cyc), 32'd3);
    add_req(1, 32'h200, 1'b0, 3'b010, 32'h0);
    run_episode();

    // Both requesters hold reads: strict alternation.
    fixed_wait = -1;
    for (int i = 0; i < 3; i++) begin
      add_req(0, 32'h300 + 32'(4 * i), 1'b0, 3'b010, 32'h0);
      add_req(1, 32'h500 + 32'(4 * i), 1'b0, 3'b010, 32'h0);
    end
    run_episode();

    for (int ep = 0; ep < 60; ep++) begin
      int mask;
      mask = int'($urandom_range(1, 3));
      if (mask[0]) for (int k = int'($urandom_range(1, 3)); k > 0; k--) add_rand(0);
      if (mask[1]) for (int k = int'($urandom_range(1, 3)); k > 0; k--) add_rand(1);
      run_episode();
    end

    // Reset in a stalled data phase: no ack, reset values, priority back to requester 0.
    fixed_wait = 6;
    add_req(0, 32'h80, 1'b0, 3'b010, 32'h0);
    predict();
    @(negedge HCLK);
    apply(0, 0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1 check_reset_values("midrst");
    chk("midrst_no_ack", 32'(exp_q.size()), 32'd1);
    chk("midrst_addr_issued", 32'(xfer_q.size()), 32'd0);
    exp_q.delete();
    xfer_q.delete();
    q0.delete();
    slv_left = 0; slv_first = 1'b0;
    HREADYOUT = 1'b1; HRESP = 1'b0;
    rr_last = 1'b1; last_rd = 32'h0;
    req_i = 2'b00;
    HRESETn = 1'b1;
    fixed_wait = 0;
    add_req(0, 32'h10, 1'b0, 3'b010, 32'h0);
    add_req(1, 32'h20, 1'b0, 3'b010, 32'h0);
    run_episode();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("xfers_drained", 32'(xfer_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
